// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM frame-buffer scheduler.
package sdram_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } sched_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    typedef logic [1:0] buf_idx_t;

    function automatic logic [ADDR_W-1:0] buf_base(input buf_idx_t b, input logic [ADDR_W-1:0] stride);
        return ADDR_W'(b) * stride;
    endfunction

    // With a and b distinct members of {0,1,2}, 3-a-b is the remaining one.
    function automatic buf_idx_t third_buf(input buf_idx_t a, input buf_idx_t b);
        return buf_idx_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/sdram_buf_ptr.sv
// Burst pointer for one side of the scheduler: wrap compare, pending vsync
// and registered base+offset burst address.
module sdram_buf_ptr
    import sdram_pkg::*;
#(
    parameter int                BURST_LEN   = 8,
    parameter int                FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = 24'h080000,
    parameter buf_idx_t          RST_BUF     = 2'd0,
    parameter bit                EVT_IS_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vsync,
    input  logic              i_active,
    input  logic              i_ack,
    input  buf_idx_t          i_buf_nxt,
    output logic              o_evt,
    output logic [ADDR_W-1:0] o_add
);

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_add;
    logic              r_pend;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_pend;
    logic              w_apply;
    logic              w_ack_acc;
    logic              w_last;

    assign w_ack_acc = i_active & i_ack;
    assign w_pend    = r_pend | i_vsync;
    // A vsync never moves the pointer under a live request, only between bursts or on its ack.
    assign w_apply   = w_pend & (~i_active | i_ack);
    assign w_last    = (r_ptr + STEP) >= FRAME;

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_apply || (w_ack_acc && w_last)) begin
            w_ptr_nxt = '0;
        end else if (w_ack_acc) begin
            w_ptr_nxt = r_ptr + STEP;
        end
    end

    // Write side needs frame completion; read side needs the vsync restart.
    assign o_evt = EVT_IS_WRAP ? (w_ack_acc & w_last & ~w_apply) : w_apply;
    assign o_add = r_add;

    // Address is built from the next pointer/buffer so it is valid the moment req rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_pend <= 1'b0;
            r_add  <= buf_base(RST_BUF, BUF_STRIDE);
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_pend <= w_pend & ~w_apply;
            r_add  <= buf_base(i_buf_nxt, BUF_STRIDE) + w_ptr_nxt;
        end
    end

endmodule

// File: rtl/sdram_frame_sched.sv
// Triple-buffered frame scheduler arbitrating camera writes and VGA reads
// onto the SDRAM controller's write and read burst ports.
//   state   | meaning
//   ST_IDLE | no request out; pick next side (round-robin when both ready)
//   ST_WR   | wr_sdram_req high until wr_sdram_ack
//   ST_RD   | rd_sdram_req high until rd_sdram_ack
module sdram_frame_sched
    import sdram_pkg::*;
#(
    parameter int                BURST_LEN   = 8,
    parameter int                FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BUF_STRIDE  = 24'h080000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              vga_vsync,
    input  logic              wr_ready,
    input  logic              rd_ready,
    output logic              wr_sdram_req,
    input  logic              wr_sdram_ack,
    output logic [ADDR_W-1:0] wr_sdram_add,
    output logic              rd_sdram_req,
    input  logic              rd_sdram_ack,
    output logic [ADDR_W-1:0] rd_sdram_add,
    output logic              wr_frame_done,
    output buf_idx_t          wr_buf,
    output buf_idx_t          rd_buf
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    grant_t       r_last_grant;
    grant_t       w_grant_nxt;
    buf_idx_t     r_wr_buf;
    buf_idx_t     r_rd_buf;
    buf_idx_t     r_done_buf;
    logic         r_frame_done;
    buf_idx_t     w_wr_buf_nxt;
    buf_idx_t     w_rd_buf_nxt;
    buf_idx_t     w_done_buf_nxt;
    logic         w_wr_frame_end;
    logic         w_rd_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_RD;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (wr_ready && (!rd_ready || r_last_grant == GRANT_RD)) begin
                    w_state_nxt = ST_WR;
                end else if (rd_ready) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                if (wr_sdram_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = GRANT_WR;
                end
            end
            ST_RD: begin
                if (rd_sdram_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = GRANT_RD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wr_sdram_req = (r_state == ST_WR);
    assign rd_sdram_req = (r_state == ST_RD);

    sdram_buf_ptr #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS),
        .BUF_STRIDE (BUF_STRIDE),
        .RST_BUF    (2'd0),
        .EVT_IS_WRAP(1'b1)
    ) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vsync  (cam_vsync),
        .i_active (wr_sdram_req),
        .i_ack    (wr_sdram_ack),
        .i_buf_nxt(w_wr_buf_nxt),
        .o_evt    (w_wr_frame_end),
        .o_add    (wr_sdram_add)
    );

    sdram_buf_ptr #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS),
        .BUF_STRIDE (BUF_STRIDE),
        .RST_BUF    (2'd1),
        .EVT_IS_WRAP(1'b0)
    ) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vsync  (vga_vsync),
        .i_active (rd_sdram_req),
        .i_ack    (rd_sdram_ack),
        .i_buf_nxt(w_rd_buf_nxt),
        .o_evt    (w_rd_restart),
        .o_add    (rd_sdram_add)
    );

    // When completion and display vsync coincide, the display takes the frame just finished.
    always_comb begin
        w_wr_buf_nxt   = r_wr_buf;
        w_rd_buf_nxt   = r_rd_buf;
        w_done_buf_nxt = r_done_buf;
        if (w_wr_frame_end) begin
            w_done_buf_nxt = r_wr_buf;
            w_wr_buf_nxt   = third_buf(r_wr_buf, r_rd_buf);
        end
        if (w_rd_restart) begin
            w_rd_buf_nxt = w_wr_frame_end ? r_wr_buf : r_done_buf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_buf     <= 2'd0;
            r_rd_buf     <= 2'd1;
            r_done_buf   <= 2'd1;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_buf     <= w_wr_buf_nxt;
            r_rd_buf     <= w_rd_buf_nxt;
            r_done_buf   <= w_done_buf_nxt;
            r_frame_done <= w_wr_frame_end;
        end
    end

    assign wr_frame_done = r_frame_done;
    assign wr_buf        = r_wr_buf;
    assign rd_buf        = r_rd_buf;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Randomized and directed bench for sdram_frame_sched against a frame-level
// reference model of arbitration, pointers and buffer rotation.
module tb_sdram_frame_sched;

    localparam int          BL     = 8;
    localparam int          FW     = 128;
    localparam logic [23:0] STRIDE = 24'h080000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        vga_vsync = 1'b0;
    logic        wr_ready = 1'b0;
    logic        rd_ready = 1'b0;
    logic        wr_sdram_ack = 1'b0;
    logic        rd_sdram_ack = 1'b0;
    logic        wr_sdram_req;
    logic        rd_sdram_req;
    logic [23:0] wr_sdram_add;
    logic [23:0] rd_sdram_add;
    logic        wr_frame_done;
    logic [1:0]  wr_buf;
    logic [1:0]  rd_buf;

    sdram_frame_sched #(
        .BURST_LEN  (BL),
        .FRAME_WORDS(FW),
        .BUF_STRIDE (STRIDE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cam_vsync    (cam_vsync),
        .vga_vsync    (vga_vsync),
        .wr_ready     (wr_ready),
        .rd_ready     (rd_ready),
        .wr_sdram_req (wr_sdram_req),
        .wr_sdram_ack (wr_sdram_ack),
        .wr_sdram_add (wr_sdram_add),
        .rd_sdram_req (rd_sdram_req),
        .rd_sdram_ack (rd_sdram_ack),
        .rd_sdram_add (rd_sdram_add),
        .wr_frame_done(wr_frame_done),
        .wr_buf       (wr_buf),
        .rd_buf       (rd_buf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which port holds the bus, where each side is in its
    // frame, and which buffer each side owns.
    typedef enum {M_IDLE, M_WR, M_RD} mstate_t;
    mstate_t m_st;
    bit      m_last_wr;
    int      m_wr_ptr, m_rd_ptr;
    int      m_wr_buf, m_rd_buf, m_done_buf;
    bit      m_cam_pend, m_vga_pend, m_done_pulse;
    int      m_wait;
    int      lat_min = 0, lat_max = 0;
    bit      stray_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_last_wr = 0;
        m_wr_ptr = 0; m_rd_ptr = 0;
        m_wr_buf = 0; m_rd_buf = 1; m_done_buf = 1;
        m_cam_pend = 0; m_vga_pend = 0; m_done_pulse = 0; m_wait = 0;
    endtask

    task automatic model_step(input bit wr_rdy, input bit rd_rdy, input bit cvs, input bit vvs,
                              input bit wack, input bit rack);
        bit wr_acc, rd_acc, cam_p, vga_p, cam_ap, vga_ap, fend;
        int ow, orr, od;
        wr_acc = (m_st == M_WR) && wack;
        rd_acc = (m_st == M_RD) && rack;
        cam_p  = m_cam_pend || cvs;
        vga_p  = m_vga_pend || vvs;
        cam_ap = cam_p && (m_st != M_WR || wr_acc);
        vga_ap = vga_p && (m_st != M_RD || rd_acc);
        fend   = wr_acc && !cam_ap && (m_wr_ptr + BL >= FW);
        if (cam_ap) m_wr_ptr = 0;
        else if (wr_acc) m_wr_ptr = fend ? 0 : m_wr_ptr + BL;
        if (vga_ap) m_rd_ptr = 0;
        else if (rd_acc) m_rd_ptr = (m_rd_ptr + BL) % FW;
        ow = m_wr_buf; orr = m_rd_buf; od = m_done_buf;
        if (fend) begin
            m_done_buf = ow;
            for (int b = 0; b < 3; b++) if (b != ow && b != orr) m_wr_buf = b;
        end
        if (vga_ap) m_rd_buf = fend ? ow : od;
        m_done_pulse = fend;
        m_cam_pend = cam_p && !cam_ap;
        m_vga_pend = vga_p && !vga_ap;
        case (m_st)
            M_IDLE: begin
                if (wr_rdy && (!rd_rdy || !m_last_wr)) m_st = M_WR;
                else if (rd_rdy) m_st = M_RD;
                if (m_st != M_IDLE) m_wait = $urandom_range(lat_max, lat_min);
            end
            M_WR: if (wack) begin m_st = M_IDLE; m_last_wr = 1; end
            M_RD: if (rack) begin m_st = M_IDLE; m_last_wr = 0; end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("wr_req", wr_sdram_req, m_st == M_WR);
        chk("rd_req", rd_sdram_req, m_st == M_RD);
        chk("wr_add", wr_sdram_add, m_wr_buf * int'(STRIDE) + m_wr_ptr);
        chk("rd_add", rd_sdram_add, m_rd_buf * int'(STRIDE) + m_rd_ptr);
        chk("wr_buf", wr_buf, m_wr_buf);
        chk("rd_buf", rd_buf, m_rd_buf);
        chk("frame_done", wr_frame_done, m_done_pulse);
    endtask

    // Called at a negedge: drive inputs for the next posedge, advance model, compare.
    task automatic step(input bit wr_rdy, input bit rd_rdy, input bit cvs, input bit vvs);
        bit wack, rack;
        wack = 0; rack = 0;
        if (m_st == M_WR || m_st == M_RD) begin
            if (m_wait == 0) begin
                if (m_st == M_WR) wack = 1; else rack = 1;
            end else begin
                m_wait--;
            end
        end
        if (stray_en && m_st != M_WR && $urandom_range(0, 15) == 0) wack = 1;
        if (stray_en && m_st != M_RD && $urandom_range(0, 15) == 0) rack = 1;
        wr_ready = wr_rdy; rd_ready = rd_rdy;
        cam_vsync = cvs; vga_vsync = vvs;
        wr_sdram_ack = wack; rd_sdram_ack = rack;
        model_step(wr_rdy, rd_rdy, cvs, vvs, wack, rack);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 0;
        wr_ready = 0; rd_ready = 0; cam_vsync = 0; vga_vsync = 0;
        wr_sdram_ack = 0; rd_sdram_ack = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n, nr, side;
        bit  pw, pr, seen;

        // Reset values
        do_reset();
        chk("rst_wr_add", wr_sdram_add, 32'h000000);
        chk("rst_rd_add", rd_sdram_add, 32'h080000);
        chk("rst_wr_buf", wr_buf, 0);
        chk("rst_rd_buf", rd_buf, 1);
        chk("rst_wr_req", wr_sdram_req, 0);

        // Writes only, ack four cycles into each request
        lat_min = 4; lat_max = 4; stray_en = 0;
        n = 0; pw = 0;
        for (int c = 0; c < 80 && n < 3; c++) begin
            step(1, 0, 0, 0);
            if (wr_sdram_req && !pw) begin
                chk("t1_add", wr_sdram_add, 32'(n * BL));
                n++;
            end
            pw = wr_sdram_req;
        end
        chk("t1_bursts", n, 3);

        // Both ready: grants alternate starting with write
        do_reset();
        lat_min = 0; lat_max = 3;
        n = 0; nr = 0; pw = 0; pr = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            step(1, 1, 0, 0);
            chk("t2_excl", wr_sdram_req & rd_sdram_req, 0);
            if ((wr_sdram_req && !pw) || (rd_sdram_req && !pr)) begin
                side = rd_sdram_req ? 1 : 0;
                chk("t2_grant", side, n % 2);
                if (side == 1) begin
                    chk("t2_rd_add", rd_sdram_add, 32'h080000 + nr * BL);
                    nr++;
                end
                n++;
            end
            pw = wr_sdram_req; pr = rd_sdram_req;
        end
        chk("t2_grants", n, 4);

        // Finish frame 0
        lat_min = 0; lat_max = 0;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            step(1, 0, 0, 0);
            if (wr_frame_done) seen = 1;
        end
        chk("t3_done_seen", seen, 1);
        chk("t3_wr_buf", wr_buf, 2);
        chk("t3_rd_buf", rd_buf, 1);
        step(0, 0, 0, 0);
        chk("t3_done_one_cycle", wr_frame_done, 0);
        for (int c = 0; c < 10 && !wr_sdram_req; c++) step(1, 0, 0, 0);
        chk("t3_next_add", wr_sdram_add, 32'h100000);

        // Display switches to finished frame 0; next write frame lands in buffer 1
        step(0, 0, 0, 1);
        chk("t4_rd_buf", rd_buf, 0);
        for (int c = 0; c < 20 && !rd_sdram_req; c++) step(0, 1, 0, 0);
        chk("t4_rd_add", rd_sdram_add, 32'h000000);
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            step(1, 0, 0, 0);
            if (wr_frame_done) seen = 1;
        end
        chk("t4_done_seen", seen, 1);
        chk("t4_wr_buf", wr_buf, 1);

        // cam_vsync during a held write request restarts buffer 2
        do_reset();
        lat_min = 0; lat_max = 0;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            step(1, 0, 0, 0);
            if (wr_frame_done) seen = 1;
        end
        lat_min = 3; lat_max = 3;
        for (int c = 0; c < 100 && !(m_st == M_WR && m_wr_ptr == 2 * BL); c++) step(1, 0, 0, 0);
        chk("t5_req_held", wr_sdram_req, 1);
        step(1, 0, 1, 0);
        seen = 0; pw = 1;
        for (int c = 0; c < 40; c++) begin
            step(1, 0, 0, 0);
            if (wr_frame_done) seen = 1;
            if (wr_sdram_req && !pw) break;
            pw = wr_sdram_req;
        end
        chk("t5_add", wr_sdram_add, 32'h100000);
        chk("t5_wr_buf", wr_buf, 2);
        chk("t5_no_done", seen, 0);

        // Frame completion and vga_vsync on the same cycle
        lat_min = 0; lat_max = 0;
        for (int c = 0; c < 400 && !(m_st == M_WR && m_wr_ptr == FW - BL && m_wait == 0); c++)
            step(1, 0, 0, 0);
        chk("t6_pre_wr_buf", wr_buf, 2);
        step(1, 0, 0, 1);
        chk("t6_done", wr_frame_done, 1);
        chk("t6_rd_buf", rd_buf, 2);
        chk("t6_wr_buf", wr_buf, 0);

        // Random traffic with stray acks and vsyncs
        lat_min = 0; lat_max = 3; stray_en = 1;
        for (int c = 0; c < 4000; c++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);

        // Reset mid-burst drops the request without a clock edge
        stray_en = 0; lat_min = 6; lat_max = 6;
        for (int c = 0; c < 50 && m_st != M_WR; c++) step(1, 0, 0, 0);
        chk("rst_mid_req_before", wr_sdram_req, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_req_after", wr_sdram_req, 0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
